// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin sequencer for a shared WIDTH-bit register bank.
// Define REG_ARB_LOCK_EN to add the lock input for back-to-back ops by one owner.
module reg_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arhat,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
`ifdef REG_ARB_LOCK_EN
  input  logic [1:0]       lock,
`endif
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qhat
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state;
  logic             prio;
  logic             owner;
  logic [1:0]       op;
  logic [WIDTH-1:0] mask;
  logic             winner;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  // A lone requester wins outright; a tie goes to prio.
  always_comb begin
    winner = prio;
    if (req == 2'b01)
      winner = 1'b0;
    else if (req == 2'b10)
      winner = 1'b1;
  end

  function automatic logic [1:0] onehot(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] o,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] m);
    case (o)
      OP_LOAD:  return m;
      OP_SET:   return cur | m;
      OP_CLEAR: return cur & ~m;
      default:  return cur ^ m;
    endcase
  endfunction

  always_ff @(posedge clk or negedge arhat) begin
    if (!arhat) begin
      state <= IDLE;
      q     <= '0;
      gnt   <= 2'b00;
      done  <= 2'b00;
      busy  <= 1'b0;
      prio  <= 1'b0;
      owner <= 1'b0;
      op    <= 2'b00;
      mask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner <= winner;
            op    <= winner ? op1 : op0;
            mask  <= winner ? data1 : data0;
            gnt   <= onehot(winner);
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          q     <= apply_op(op, q, mask);
          gnt   <= 2'b00;
          done  <= onehot(owner);
          state <= DONE;
        end
        DONE: begin
          done <= 2'b00;
`ifdef REG_ARB_LOCK_EN
          if (req[owner] && lock[owner]) begin
            // Owner keeps the bank: recapture and re-execute without touching prio.
            op    <= owner ? op1 : op0;
            mask  <= owner ? data1 : data0;
            gnt   <= onehot(owner);
            state <= EXEC;
          end else begin
            prio  <= ~owner;
            busy  <= 1'b0;
            state <= IDLE;
          end
`else
          prio  <= ~owner;
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end
        default: begin
          gnt   <= 2'b00;
          done  <= 2'b00;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign qhat = ~q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter (WIDTH=8).
// Covers the REG_ARB_LOCK_EN lock sequence when that macro is defined.
module tb_reg_bank_arbiter;

  logic       clk = 1'b0;
  logic       arhat = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] op0 = 2'b00;
  logic [1:0] op1 = 2'b00;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;
  logic [7:0] q;
  logic [7:0] qhat;
`ifdef REG_ARB_LOCK_EN
  logic [1:0] lock = 2'b00;
`endif

  int checks = 0;
  int errors = 0;

  reg_bank_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .arhat(arhat), .req(req), .op0(op0), .op1(op1),
    .data0(data0), .data1(data1),
`ifdef REG_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .done(done), .busy(busy), .q(q), .qhat(qhat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction for the requester in exp_gnt; req must already be high.
  // keep leaves that requester's req high through its done cycle.
  task automatic grant_cycle(input string tag, input logic [1:0] exp_gnt,
                             input logic [7:0] exp_q, input bit keep);
    tick();
    check({tag, ".gnt"}, {30'b0, gnt}, {30'b0, exp_gnt});
    check({tag, ".busy"}, {31'b0, busy}, 32'd1);
    check({tag, ".done0"}, {30'b0, done}, 32'd0);
    tick();
    check({tag, ".q"}, {24'b0, q}, {24'b0, exp_q});
    check({tag, ".qhat"}, {24'b0, qhat}, {24'b0, ~exp_q});
    check({tag, ".done"}, {30'b0, done}, {30'b0, exp_gnt});
    check({tag, ".gnt_off"}, {30'b0, gnt}, 32'd0);
    if (!keep) req = req & ~exp_gnt;
    tick();
    check({tag, ".done_end"}, {30'b0, done}, 32'd0);
    check({tag, ".busy_end"}, {31'b0, busy}, 32'd0);
    check({tag, ".gnt_end"}, {30'b0, gnt}, 32'd0);
    $display("op %s gnt=%b q=%h done_seen", tag, exp_gnt, q);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst.q", {24'b0, q}, 32'h00);
    check("rst.qhat", {24'b0, qhat}, 32'hFF);
    check("rst.gnt", {30'b0, gnt}, 32'd0);
    check("rst.done", {30'b0, done}, 32'd0);
    check("rst.busy", {31'b0, busy}, 32'd0);
    arhat = 1'b1;
    tick();

    // Requester 0 LOAD 0xA5
    op0 = 2'b00; data0 = 8'hA5; req = 2'b01;
    grant_cycle("r0_load_a5", 2'b01, 8'hA5, 1'b0);

    // Requester 1 SET / CLEAR / TOGGLE, then zero-mask SET
    op1 = 2'b01; data1 = 8'h0F; req = 2'b10;
    grant_cycle("r1_set_0f", 2'b10, 8'hAF, 1'b0);
    op1 = 2'b10; data1 = 8'h81; req = 2'b10;
    grant_cycle("r1_clr_81", 2'b10, 8'h2E, 1'b0);
    op1 = 2'b11; data1 = 8'hFF; req = 2'b10;
    grant_cycle("r1_tog_ff", 2'b10, 8'hD1, 1'b0);
    op1 = 2'b01; data1 = 8'h00; req = 2'b10;
    grant_cycle("r1_set_00", 2'b10, 8'hD1, 1'b0);

    // Fresh reset, simultaneous requests: 0 then 1
    arhat = 1'b0;
    #1;
    check("rst2.q", {24'b0, q}, 32'h00);
    arhat = 1'b1;
    op0 = 2'b00; data0 = 8'h11; op1 = 2'b00; data1 = 8'h22; req = 2'b11;
    grant_cycle("pair1_r0", 2'b01, 8'h11, 1'b0);
    grant_cycle("pair1_r1", 2'b10, 8'h22, 1'b0);
    // r0 alone leaves prio at 1, so the next tie goes to r1 first
    op0 = 2'b11; data0 = 8'hF0; req = 2'b01;
    grant_cycle("solo_r0", 2'b01, 8'hD2, 1'b0);
    op0 = 2'b00; data0 = 8'h33; op1 = 2'b00; data1 = 8'h44; req = 2'b11;
    grant_cycle("pair2_r1", 2'b10, 8'h44, 1'b0);
    grant_cycle("pair2_r0", 2'b01, 8'h33, 1'b0);

    // Reset pulsed during EXEC of LOAD 0x3C
    op0 = 2'b00; data0 = 8'h3C; req = 2'b01;
    tick();
    check("abort.gnt_pre", {30'b0, gnt}, 32'b01);
    #2 arhat = 1'b0;
    #1;
    check("abort.q", {24'b0, q}, 32'h00);
    check("abort.gnt", {30'b0, gnt}, 32'd0);
    check("abort.busy", {31'b0, busy}, 32'd0);
    req = 2'b00;
    #1 arhat = 1'b1;
    tick();
    check("abort.done1", {30'b0, done}, 32'd0);
    tick();
    check("abort.done2", {30'b0, done}, 32'd0);
    check("abort.q_hold", {24'b0, q}, 32'h00);
    $display("op abort_load_3c q=%h", q);
    op0 = 2'b00; data0 = 8'h5A; req = 2'b01;
    grant_cycle("post_abort", 2'b01, 8'h5A, 1'b0);

    // r0 keeps req through done while r1 waits: r1 goes next, then r0 again
    op0 = 2'b00; data0 = 8'h01; req = 2'b01;
    tick();
    check("hold.gnt0", {30'b0, gnt}, 32'b01);
    op1 = 2'b11; data1 = 8'h0F; req = 2'b11;
    tick();
    check("hold.q0", {24'b0, q}, 32'h01);
    check("hold.done0", {30'b0, done}, 32'b01);
    tick();
    check("hold.idle", {31'b0, busy}, 32'd0);
    grant_cycle("hold_r1", 2'b10, 8'h0E, 1'b0);
    grant_cycle("hold_r0", 2'b01, 8'h01, 1'b0);

`ifdef REG_ARB_LOCK_EN
    // Locked run of three TOGGLE 0x01 by r0 while r1 waits
    op0 = 2'b11; data0 = 8'h01; lock = 2'b01; req = 2'b01;
    tick();
    check("lock.gnt_a", {30'b0, gnt}, 32'b01);
    op1 = 2'b00; data1 = 8'hAA; req = 2'b11;
    tick();
    check("lock.q_a", {24'b0, q}, 32'h00);
    check("lock.done_a", {30'b0, done}, 32'b01);
    tick();
    check("lock.gnt_b", {30'b0, gnt}, 32'b01);
    check("lock.busy_b", {31'b0, busy}, 32'd1);
    tick();
    check("lock.q_b", {24'b0, q}, 32'h01);
    tick();
    check("lock.gnt_c", {30'b0, gnt}, 32'b01);
    tick();
    check("lock.q_c", {24'b0, q}, 32'h00);
    check("lock.done_c", {30'b0, done}, 32'b01);
    lock = 2'b00; req = 2'b10;
    tick();
    check("lock.release", {31'b0, busy}, 32'd0);
    grant_cycle("lock_r1", 2'b10, 8'hAA, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
